// File: rtl/runcode_pack.sv
`default_nettype none
// ============================================================================
// Module      : runcode_pack
// Description : Run-mode codeword assembler for the LOCO-I encoder. Builds a
//               unary prefix of ones followed by a masked suffix field and
//               streams the codeword MSB-first in beats of up to WORD_W bits.
//               k and glimit are latched per codeword and travel with every
//               beat.
// Option      : RUNCODE_LEN_CHK_EN - when defined, err flags codewords whose
//               length exceeds glimit + k. When undefined, err is tied to 0.
// Ports       : clk, reset (async, active-low)
//               in_valid/in_ready   - codeword request handshake
//               prefix_len, suffix, suffix_len, k, limit_reduce - request
//               out_valid/out_ready - beat handshake
//               code, code_len, out_last, k_out, glimit, err - beat fields
// Revision    : 1.0 - initial release
// ============================================================================
module runcode_pack #(
  parameter int WORD_W      = 32,
  parameter int LEN_W       = 6,
  parameter int PLEN_W      = 6,
  parameter int SUF_W       = 11,
  parameter int SLEN_W      = 4,
  parameter int K_W         = 5,
  parameter int GLIMIT_BASE = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PLEN_W-1:0] prefix_len,
  input  logic [SUF_W-1:0]  suffix,
  input  logic [SLEN_W-1:0] suffix_len,
  input  logic [3:0]        k,
  input  logic [3:0]        limit_reduce,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] code,
  output logic [LEN_W-1:0]  code_len,
  output logic              out_last,
  output logic [K_W-1:0]    k_out,
  output logic [5:0]        glimit,
  output logic              err
);

  // Wide enough for prefix + suffix length without overflow.
  localparam int TOT_W = ((PLEN_W > LEN_W) ? PLEN_W : LEN_W) + 2;
  // Holds fewer than WORD_W ones followed by the longest possible suffix.
  localparam int CW_W  = WORD_W + (1 << SLEN_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  state_t              state_q;
  logic [PLEN_W-1:0]   rem_q;       // ones still to be emitted
  logic [SUF_W-1:0]    suf_q;       // suffix bits still to be emitted (masked)
  logic [SLEN_W-1:0]   slen_q;      // number of suffix bits still to be emitted
  logic                out_valid_q;
  logic [WORD_W-1:0]   code_q;
  logic [LEN_W-1:0]    code_len_q;
  logic                last_q;
  logic [K_W-1:0]      k_q;
  logic [5:0]          glimit_q;

  logic                accept;
  logic                advance;
  logic [PLEN_W-1:0]   src_rem;
  logic [SUF_W-1:0]    src_suf;
  logic [SLEN_W-1:0]   src_slen;
  logic [TOT_W-1:0]    total;
  logic                fits;
  logic [CW_W-1:0]     cw;
  logic [WORD_W-1:0]   code_d;
  logic [LEN_W-1:0]    code_len_d;
  logic [PLEN_W-1:0]   rem_d;
  logic [SLEN_W-1:0]   slen_d;
  logic [SUF_W-1:0]    suf_d;
  logic [5:0]          glimit_d;

  // Mask with the low n bits set; n may exceed SUF_W (upper bits are zero).
  function automatic logic [SUF_W-1:0] suf_mask(input logic [SLEN_W-1:0] n);
    logic [SUF_W-1:0] m;
    m = '0;
    for (int i = 0; i < SUF_W; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_LAST) && out_ready);
  assign accept   = in_valid && in_ready;
  // A RUN beat has been taken and the next beat must be formed.
  assign advance  = (state_q == ST_RUN) && out_ready;
  assign glimit_d = 6'(GLIMIT_BASE - int'(limit_reduce));

  // Beat formation. The source is either a freshly accepted request or the
  // remainder of the codeword in flight. The beat always carries the next
  // min(total, WORD_W) bits of the codeword, MSB-first. When fewer than
  // WORD_W ones remain but the suffix does not fit in the same word, the beat
  // is topped up with the leading suffix bits so that beat boundaries fall
  // every WORD_W bits of the codeword.
  always_comb begin
    src_rem  = rem_q;
    src_suf  = suf_q;
    src_slen = slen_q;
    if (accept) begin
      src_rem  = prefix_len;
      src_slen = suffix_len;
      src_suf  = suffix & suf_mask(suffix_len);
    end

    total      = TOT_W'(src_rem) + TOT_W'(src_slen);
    fits       = (total <= TOT_W'(WORD_W));
    code_len_d = fits ? LEN_W'(total) : LEN_W'(WORD_W);
    cw         = '0;

    if (TOT_W'(src_rem) >= TOT_W'(WORD_W)) begin
      // A whole word of ones; the suffix is untouched.
      code_d = '1;
      rem_d  = src_rem - PLEN_W'(WORD_W);
      slen_d = src_slen;
    end else begin
      cw     = (((CW_W'(1) << src_rem) - CW_W'(1)) << src_slen) | CW_W'(src_suf);
      code_d = WORD_W'(cw >> (total - TOT_W'(code_len_d)));
      rem_d  = '0;
      // Only meaningful when the codeword continues into another beat.
      slen_d = SLEN_W'(total - TOT_W'(WORD_W));
    end

    suf_d = src_suf & suf_mask(slen_d);
  end

`ifdef RUNCODE_LEN_CHK_EN
  logic err_q;
  logic err_d;
  assign err_d = (TOT_W'(prefix_len) + TOT_W'(suffix_len)) >
                 (TOT_W'(glimit_d) + TOT_W'(k));
  assign err   = err_q;
`else
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      suf_q       <= '0;
      slen_q      <= '0;
      out_valid_q <= 1'b0;
      code_q      <= '0;
      code_len_q  <= '0;
      last_q      <= 1'b0;
      k_q         <= '0;
      glimit_q    <= '0;
`ifdef RUNCODE_LEN_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      if (accept || advance) begin
        out_valid_q <= 1'b1;
        code_q      <= code_d;
        code_len_q  <= code_len_d;
        last_q      <= fits;
        rem_q       <= rem_d;
        suf_q       <= suf_d;
        slen_q      <= slen_d;
        state_q     <= fits ? ST_LAST : ST_RUN;
        if (accept) begin
          k_q      <= K_W'(k);
          glimit_q <= glimit_d;
`ifdef RUNCODE_LEN_CHK_EN
          err_q    <= err_d;
`endif
        end
      end else if ((state_q == ST_LAST) && out_ready) begin
        // Final beat taken with no new request waiting.
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b0;
        code_q      <= '0;
        code_len_q  <= '0;
        last_q      <= 1'b0;
`ifdef RUNCODE_LEN_CHK_EN
        err_q       <= 1'b0;
`endif
      end
    end
  end

  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign code_len  = code_len_q;
  assign out_last  = last_q;
  assign k_out     = k_q;
  assign glimit    = glimit_q;

endmodule
`default_nettype wire
